// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame buffer feeding the FFT: fills one bank from the mic stream while the other streams out.
// First sample two cycles after a frame starts streaming; fft_ready stalls hold the output stable; a full write bank drops samples.
module fft_frame_ctrl #(
    parameter int W        = 16,
    parameter int NSamples = 1024,
    parameter int TIMEOUT  = 65536
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sample_data,
    input  logic         sample_valid,
    output logic [W-1:0] fft_data,
    output logic         fft_valid,
    input  logic         fft_ready,
    output logic         fft_sof,
    output logic         fft_eof,
    input  logic         result_valid,
    output logic [15:0]  frame_count,
    output logic         overrun,
    output logic         timeout,
    output logic         busy
);
    localparam int AW = $clog2(NSamples);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RESULT} state_t;

    logic [W-1:0]  mem [0:2*NSamples-1];

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic          wb_q, wb_d, rb_q, rb_d;
    logic [1:0]    full_q, full_d;
    logic          iss_done_q, iss_done_d;
    logic          s1_vld_q, s1_vld_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
    logic [W-1:0]  s1_dat_q;
    logic          out_vld_q, out_vld_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
    logic [W-1:0]  out_dat_q, out_dat_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [15:0]   fc_q, fc_d;
    logic          ovr_q, ovr_d, to_q, to_d;

    logic wr_en, out_adv, eof_xfer, issue;

    assign wr_en    = sample_valid && !full_q[wb_q];
    assign out_adv  = !out_vld_q || fft_ready;
    assign eof_xfer = out_vld_q && fft_ready && out_eof_q;
    // Only fetch when the RAM-output stage is free or draining this cycle.
    assign issue    = (state_q == STREAM) && !iss_done_q && (!s1_vld_q || out_adv);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wb_q, wp_q}] <= sample_data;
        if (issue)
            s1_dat_q <= mem[{rb_q, rp_q}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            full_q     <= '0;
            iss_done_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            out_dat_q  <= '0;
            wait_q     <= '0;
            fc_q       <= '0;
            ovr_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            full_q     <= full_d;
            iss_done_q <= iss_done_d;
            s1_vld_q   <= s1_vld_d;
            s1_sof_q   <= s1_sof_d;
            s1_eof_q   <= s1_eof_d;
            out_vld_q  <= out_vld_d;
            out_sof_q  <= out_sof_d;
            out_eof_q  <= out_eof_d;
            out_dat_q  <= out_dat_d;
            wait_q     <= wait_d;
            fc_q       <= fc_d;
            ovr_q      <= ovr_d;
            to_q       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        full_d     = full_q;
        iss_done_d = iss_done_q;
        s1_vld_d   = s1_vld_q;
        s1_sof_d   = s1_sof_q;
        s1_eof_d   = s1_eof_q;
        out_vld_d  = out_vld_q;
        out_sof_d  = out_sof_q;
        out_eof_d  = out_eof_q;
        out_dat_d  = out_dat_q;
        wait_d     = wait_q;
        fc_d       = fc_q;
        ovr_d      = ovr_q;
        to_d       = to_q;

        // Read clear and write set always hit different banks, so order is irrelevant.
        if (eof_xfer) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end
        if (wr_en) begin
            wp_d = wp_q + 1'b1;
            if (wp_q == AW'(NSamples - 1)) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end else if (sample_valid) begin
            ovr_d = 1'b1;
        end

        if (issue) begin
            s1_vld_d = 1'b1;
            s1_sof_d = (rp_q == '0);
            s1_eof_d = (rp_q == AW'(NSamples - 1));
            rp_d     = rp_q + 1'b1;
            if (rp_q == AW'(NSamples - 1))
                iss_done_d = 1'b1;
        end else if (out_adv) begin
            s1_vld_d = 1'b0;
        end

        if (out_adv) begin
            out_vld_d = s1_vld_q;
            out_sof_d = s1_vld_q && s1_sof_q;
            out_eof_d = s1_vld_q && s1_eof_q;
            if (s1_vld_q)
                out_dat_d = s1_dat_q;
        end

        case (state_q)
            IDLE: begin
                if (full_q[rb_q]) begin
                    state_d    = STREAM;
                    rp_d       = '0;
                    iss_done_d = 1'b0;
                end
            end
            STREAM: begin
                if (eof_xfer) begin
                    state_d = WAIT_RESULT;
                    wait_d  = '0;
                end
            end
            WAIT_RESULT: begin
                if (result_valid) begin
                    fc_d    = fc_q + 16'd1;
                    state_d = IDLE;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fft_data    = out_dat_q;
    assign fft_valid   = out_vld_q;
    assign fft_sof     = out_sof_q;
    assign fft_eof     = out_eof_q;
    assign frame_count = fc_q;
    assign overrun     = ovr_q;
    assign timeout     = to_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer between the mic sample stream and the FFT pitch datapath.
- Captures audio samples into a two-bank (ping-pong) frame buffer and streams each complete NSamples frame to the FFT input with a valid/ready handshake and frame markers.
- Waits for the pitch stage to report the frame done before starting the next frame.
- Counts processed frames and flags dropped samples and stalled results.

Parameters:
- W, 16, sample width in bits.
- NSamples, 1024, samples per frame; power of two, minimum 4.
- TIMEOUT, 65536, max clk cycles in WAIT_RESULT before the frame is abandoned.

Ports:
- clk  in  1  system clock; every register is on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- sample_data  in  W  audio sample, signed two's complement.
- sample_valid  in  1  one-cycle strobe per sample, already synchronous to clk.
- fft_data  out  W  frame sample to the FFT.
- fft_valid  out  1  fft_data is valid.
- fft_ready  in  1  FFT accepts the sample; transfer occurs when fft_valid and fft_ready are both high.
- fft_sof  out  1  high with the first sample (index 0) of a frame.
- fft_eof  out  1  high with the last sample (index NSamples-1) of a frame.
- result_valid  in  1  pitch-stage pulse: the current frame is finished.
- frame_count  out  16  number of completed frames; wraps at 2^16.
- overrun  out  1  sticky; a sample was dropped because the write bank was full.
- timeout  out  1  sticky; the WAIT_RESULT limit expired.
- busy  out  1  read FSM is not in IDLE.

Behaviour:
- Reset values: fft_valid=0, fft_sof=0, fft_eof=0, fft_data=0, frame_count=0, overrun=0, timeout=0, busy=0.
- Reset also clears: write pointer wp=0, write bank wb=0, read bank rb=0, read pointer rp=0, full[1:0]=0, FSM=IDLE.
- Reset asserted mid-frame abandons both banks with no partial output.

Write side (independent of the read FSM):
- On sample_valid with full[wb]=0: mem[wb][wp] <= sample_data, and wp increments.
- When the write stores index NSamples-1: wp wraps to 0, full[wb] is set, and wb toggles, all in the same cycle.
- On sample_valid with full[wb]=1: the sample is dropped, wp and wb hold, and overrun is set.

Read FSM states: IDLE, STREAM, WAIT_RESULT.
- IDLE: when full[rb]=1, go to STREAM with rp=0.
- STREAM:
  - Presents mem[rb][rp] through a one-cycle RAM read plus an output register.
  - fft_valid first rises exactly 2 cycles after entering STREAM.
  - While fft_valid=1 and fft_ready=0, fft_data, fft_sof and fft_eof hold stable.
  - With fft_ready held high, one sample transfers per cycle, so a frame takes NSamples consecutive cycles; prefetch keeps the pipe full.
  - fft_sof is high only with index 0; fft_eof is high only with index NSamples-1.
  - On the eof transfer: full[rb] clears, rb toggles, fft_valid drops the next cycle, and the FSM goes to WAIT_RESULT.
- WAIT_RESULT:
  - On result_valid: frame_count increments and the FSM goes to IDLE.
  - If result_valid does not arrive within TIMEOUT cycles of entry: timeout is set, frame_count is unchanged, and the FSM goes to IDLE.
  - result_valid in any other state is ignored.

Simultaneous events:
- If the write side sets full[x] in the same cycle the read side clears full[y] (x≠y), both take effect.
- A write to bank x can never coincide with reading bank x, because the write side never writes a full bank.
- If IDLE sees full[rb] become set in a given cycle, STREAM is entered on the next cycle.

Sample order: samples are delivered in capture order. Bank order is strictly alternating, starting at bank 0 after reset.

Test Plan:
- NSamples=8, reset, 8 sample_valid strobes with data 1..8, fft_ready=1 → STREAM entered; 2 cycles later 8 consecutive transfers of data 1..8; sof on 1, eof on 8; busy=1; then WAIT_RESULT.
- Continue the test above, pulse result_valid → frame_count=1, FSM IDLE, busy=0; a second 8 samples (9..16) go to bank 1 and stream as 9..16.
- Backpressure: fft_ready toggles 1,0,0,1,... during STREAM → each stalled sample holds data, sof and eof; all 8 values are delivered once, in order.
- Overrun: fft_ready=0, 17 samples arrive → both banks full, sample 17 dropped, overrun=1; after release, the frames stream as 1..8 then 9..16.
- Timeout: TIMEOUT=20, no result_valid → timeout=1 at cycle 20 of WAIT_RESULT, frame_count stays 0, FSM returns to IDLE and streams the next full bank.
- Reset mid-STREAM after 3 transfers → next cycle fft_valid=0, frame_count=0, overrun=0; 8 new samples stream from bank 0 with sof on the first.
